// File: rtl/amiga_bus_if.sv
// 68000-side bus signals between the CPU/DMA world and the cycle controller.
interface amiga_bus_if #(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_BITS   = 3
);
  logic [ADDR_BITS-1:0]   ADDR_HI;
  logic                   _AS;
  logic                   _DBR;
  logic                   OVL;
  logic                   _OVR;
  logic                   XRDY;
  logic [NUM_REGIONS-1:0] _CS;
  logic                   _DTACK;
  logic                   _VPA;
  logic                   _BERR;
  logic                   _DAE;

  modport master (
    output ADDR_HI, _AS, _DBR, OVL, _OVR, XRDY,
    input  _CS, _DTACK, _VPA, _BERR, _DAE
  );

  modport slave (
    input  ADDR_HI, _AS, _DBR, OVL, _OVR, XRDY,
    output _CS, _DTACK, _VPA, _BERR, _DAE
  );
endinterface

// File: rtl/amiga_bus_cycle_ctl.sv
// Clocked 68000 bus-cycle controller: region decode, wait states, DTACK/VPA
// termination, DMA stall, boot overlay and bus-error timeout.
module amiga_bus_cycle_ctl #(
  parameter int unsigned                         NUM_REGIONS  = 4,
  parameter int unsigned                         ADDR_BITS    = 3,
  parameter int unsigned                         WAIT_W       = 3,
  parameter logic [NUM_REGIONS*ADDR_BITS-1:0]    REGION_ADDR  = {3'b110, 3'b101, 3'b111, 3'b000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0]       REGION_WAIT  = {3'd0, 3'd4, 3'd1, 3'd2},
  parameter logic [NUM_REGIONS-1:0]              REGION_VPA   = 4'b0100,
  parameter logic [NUM_REGIONS-1:0]              REGION_XRDY  = 4'b1011,
  parameter logic [NUM_REGIONS-1:0]              DMA_MASK     = 4'b1001,
  parameter int unsigned                         OVL_REGION   = 1,
  parameter int unsigned                         BERR_TIMEOUT = 64
) (
  input logic        CLK,
  input logic        _RESET,
  amiga_bus_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned TMO_W = $clog2(BERR_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_BERR} state_t;

  state_t                 state_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WAIT_W-1:0]      wait_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic                   dtack_q;
  logic                   vpa_q;
  logic                   berr_q;
  logic                   dae_q;

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             stall;
  logic             abort;
  logic             ready;
  logic             tmo_hit;
  logic             dae_n;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (bus.OVL && addr_q == '0) begin
      hit = 1'b1;
      idx = IDX_W'(OVL_REGION);
    end else begin
      for (int unsigned i = NUM_REGIONS; i > 0; i--) begin
        if (REGION_ADDR[(i-1)*ADDR_BITS +: ADDR_BITS] == addr_q) begin
          hit = 1'b1;
          idx = IDX_W'(i - 1);
        end
      end
    end
  end

  always_comb begin
    stall   = hit && DMA_MASK[idx] && !bus._DBR;
    abort   = bus._AS || !bus._OVR;
    ready   = (wait_q == '0) && (bus.XRDY || !REGION_XRDY[idx_q]);
    tmo_hit = (tmo_q == TMO_W'(BERR_TIMEOUT));
    dae_n   = !(!bus._DBR && (state_q == S_IDLE ||
                              (state_q == S_DECODE && stall && !abort)));
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      tmo_q   <= '0;
      cs_q    <= '1;
      dtack_q <= 1'b1;
      vpa_q   <= 1'b1;
      berr_q  <= 1'b1;
      dae_q   <= 1'b1;
    end else begin
      dae_q <= dae_n;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        cs_q    <= '1;
        dtack_q <= 1'b1;
        vpa_q   <= 1'b1;
        berr_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!bus._AS && bus._OVR) begin
              addr_q  <= bus.ADDR_HI;
              tmo_q   <= '0;
              state_q <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (tmo_hit) begin
              berr_q  <= 1'b0;
              cs_q    <= '1;
              state_q <= S_BERR;
            end else if (!stall) begin
              tmo_q <= tmo_q + TMO_W'(1);
              if (hit) begin
                cs_q    <= ~(NUM_REGIONS'(1) << idx);
                idx_q   <= idx;
                wait_q  <= REGION_WAIT[idx*WAIT_W +: WAIT_W];
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            // Termination wins over a timeout landing on the same edge.
            if (ready) begin
              if (REGION_VPA[idx_q]) vpa_q <= 1'b0;
              else                   dtack_q <= 1'b0;
              state_q <= S_ACK;
            end else if (tmo_hit) begin
              berr_q  <= 1'b0;
              cs_q    <= '1;
              state_q <= S_BERR;
            end else begin
              if (wait_q != '0) wait_q <= wait_q - WAIT_W'(1);
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus._CS    = cs_q;
  assign bus._DTACK = dtack_q;
  assign bus._VPA   = vpa_q;
  assign bus._BERR  = berr_q;
  assign bus._DAE   = dae_q;

endmodule
